// File: rtl/hdx_pkg.sv
// rtl/hdx_pkg.sv - shared state type and constants for the half-duplex bus port
package hdx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TURN,
      ST_DRIVE,
      ST_RELEASE
   } hdx_state_e;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 4;
   localparam int STATS_W   = 16;

endpackage

// File: rtl/hdx_if.sv
// rtl/hdx_if.sv - core-side transmit/receive stream bundle of the half-duplex port
interface hdx_if
   import hdx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             tx_valid;
   logic [WIDTH-1:0] tx_data;
   logic             tx_ready;
   logic             rx_valid;
   logic [WIDTH-1:0] rx_data;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready,
      input  rx_valid,
      input  rx_data
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready,
      output rx_valid,
      output rx_data
   );

endinterface

// File: rtl/hdx_fifo.sv
// rtl/hdx_fifo.sv - transmit word FIFO with look-ahead head for back-to-back bus bursts
module hdx_fifo
   import hdx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             one_left,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] head_nxt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty    = (wr_q == rd_q);
   assign one_left = ((wr_q - rd_q) == PW'(1));
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign head     = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_ok) begin
         wr_d = wr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_d = rd_q + PW'(1);
      end
   end

   // Head after this edge: a word pushed into a draining FIFO bypasses the array.
   always_comb begin
      head_nxt = mem_q[rd_d[AW-1:0]];
      if (rd_d == wr_q) begin
         head_nxt = push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/hdx_port.sv
// rtl/hdx_port.sv - half-duplex tristate bus port; HDX_STATS_EN adds tx_count/rx_count
module hdx_port
   import hdx_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int TURN      = 1,
   parameter int MAX_BURST = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   hdx_if.slave             core,
   inout  wire [WIDTH-1:0]  bus_data,
   output logic             bus_oe,
   input  logic             peer_oe,
   output logic             err
`ifdef HDX_STATS_EN
   ,
   output logic [STATS_W-1:0] tx_count,
   output logic [STATS_W-1:0] rx_count
`endif
);

   localparam int BW = $clog2(MAX_BURST + 1);

   hdx_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic             bus_oe_q, bus_oe_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             err_q, err_d;
   logic             rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;

   logic             full;
   logic             empty;
   logic             one_left;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] head_nxt;
   logic             pop;
   logic             push_ok;

   hdx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (core.tx_valid),
      .push_data (core.tx_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .one_left  (one_left),
      .head      (head),
      .head_nxt  (head_nxt)
   );

   assign push_ok       = core.tx_valid && !full;
   assign core.tx_ready = !full;
   assign core.rx_valid = rx_valid_q;
   assign core.rx_data  = rx_data_q;
   assign bus_oe        = bus_oe_q;
   assign err           = err_q;
   assign bus_data      = bus_oe_q ? out_q : {WIDTH{1'bz}};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      burst_d  = burst_q;
      bus_oe_d = 1'b0;
      out_d    = out_q;
      err_d    = err_q;
      pop      = 1'b0;

      rx_valid_d = !bus_oe_q && peer_oe;
      rx_data_d  = rx_valid_d ? bus_data : rx_data_q;

      case (state_q)
         ST_IDLE: begin
            if (!empty && !peer_oe) begin
               if (TURN == 0) begin
                  state_d  = ST_DRIVE;
                  bus_oe_d = 1'b1;
                  out_d    = head;
                  burst_d  = '0;
               end else begin
                  state_d = ST_TURN;
                  cnt_d   = 4'(TURN);
               end
            end
         end

         ST_TURN: begin
            if (peer_oe) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'd1) begin
               state_d  = ST_DRIVE;
               cnt_d    = '0;
               bus_oe_d = 1'b1;
               out_d    = head;
               burst_d  = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_DRIVE: begin
            // The word on the bus is only retired once a cycle passes without the peer driving.
            if (peer_oe) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               burst_d = '0;
            end else begin
               pop     = 1'b1;
               burst_d = burst_q + BW'(1);
               if ((one_left && !push_ok) || (burst_q == BW'(MAX_BURST - 1))) begin
                  state_d = ST_RELEASE;
                  burst_d = '0;
               end else begin
                  bus_oe_d = 1'b1;
                  out_d    = head_nxt;
               end
            end
         end

         ST_RELEASE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         burst_q    <= '0;
         bus_oe_q   <= 1'b0;
         out_q      <= '0;
         err_q      <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         burst_q    <= burst_d;
         bus_oe_q   <= bus_oe_d;
         out_q      <= out_d;
         err_q      <= err_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

`ifdef HDX_STATS_EN
   logic [STATS_W-1:0] tx_count_q, tx_count_d;
   logic [STATS_W-1:0] rx_count_q, rx_count_d;

   always_comb begin
      tx_count_d = tx_count_q + STATS_W'(pop);
      rx_count_d = rx_count_q + STATS_W'(rx_valid_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_count_q <= '0;
         rx_count_q <= '0;
      end else begin
         tx_count_q <= tx_count_d;
         rx_count_q <= rx_count_d;
      end
   end

   assign tx_count = tx_count_q;
   assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_hdx_port.sv
// tb/tb_hdx_port.sv - scoreboard bench for hdx_port with a bench-modelled bus peer
module tb_hdx_port;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int TN = 1;
   localparam int MB = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         peer_drv = 1'b0;
   logic [W-1:0] peer_val = '0;
   logic         cap_en = 1'b1;
   wire  [W-1:0] bus_data;
   logic         bus_oe;
   logic         err;
`ifdef HDX_STATS_EN
   logic [15:0]  tx_count;
   logic [15:0]  rx_count;
`endif

   logic [W-1:0] tx_exp[$];
   logic [W-1:0] rx_exp[$];
   int           burst_exp[$];
   int           n_cmp = 0;
   int           n_fail = 0;

   hdx_if #(.WIDTH(W)) u_if ();

   assign bus_data = peer_drv ? peer_val : {W{1'bz}};

   hdx_port #(
      .WIDTH     (W),
      .DEPTH     (D),
      .TURN      (TN),
      .MAX_BURST (MB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .core     (u_if),
      .bus_data (bus_data),
      .bus_oe   (bus_oe),
      .peer_oe  (peer_drv),
      .err      (err)
`ifdef HDX_STATS_EN
      ,
      .tx_count (tx_count),
      .rx_count (rx_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   task automatic push_word(input logic [W-1:0] w);
      int t = 0;
      @(negedge clk);
      while (!u_if.tx_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!u_if.tx_ready) begin
         fail_now("push_timeout");
      end else begin
         u_if.tx_valid = 1'b1;
         u_if.tx_data  = w;
         tx_exp.push_back(w);
         @(posedge clk);
         #1;
         u_if.tx_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while ((tx_exp.size() != 0 || rx_exp.size() != 0 || bus_oe) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) fail_now(name);
      repeat (4) @(negedge clk);
   endtask

   task automatic peer_cap();
      forever begin
         @(posedge clk);
         if (rst_n && peer_drv && cap_en) rx_exp.push_back(peer_val);
      end
   endtask

   task automatic monitor();
      bit in_burst = 0;
      bit have_prev = 0;
      int blen = 0;
      int gap = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_burst  = 0;
            have_prev = 0;
            blen      = 0;
            gap       = 0;
         end else begin
            if (bus_oe) begin
               if (!in_burst) begin
                  if (have_prev) begin
                     n_cmp++;
                     if (gap < 1 + TN) begin
                        n_fail++;
                        $display("FAIL burst_gap: got %0d cycles required at least %0d", gap, 1 + TN);
                     end
                  end
                  in_burst = 1;
                  blen     = 0;
               end
               blen++;
               if (!peer_drv) begin
                  if (tx_exp.size() == 0) begin
                     fail_now("tx_unexpected_word");
                  end else begin
                     chk("tx_word", 32'(bus_data), 32'(tx_exp.pop_front()));
                  end
               end
            end else begin
               if (in_burst) begin
                  in_burst  = 0;
                  have_prev = 1;
                  gap       = 0;
                  if (burst_exp.size() == 0) fail_now("burst_unexpected");
                  else chk("burst_len", 32'(blen), 32'(burst_exp.pop_front()));
               end
               gap++;
            end
            if (u_if.rx_valid) begin
               if (rx_exp.size() == 0) fail_now("rx_unexpected");
               else chk("rx_word", 32'(u_if.rx_data), 32'(rx_exp.pop_front()));
            end
         end
      end
   endtask

   task automatic stimulus();
      u_if.tx_valid = 1'b0;
      u_if.tx_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      chk("rst_bus_oe", 32'(bus_oe), 0);
      chk("rst_tx_ready", 32'(u_if.tx_ready), 1);
      chk("rst_rx_valid", 32'(u_if.rx_valid), 0);
      chk("rst_rx_data", 32'(u_if.rx_data), 0);
      chk("rst_err", 32'(err), 0);

      // two words, one burst of 2, first word on bus after TURN cycle
      burst_exp.push_back(2);
      push_word(4'h3);
      push_word(4'hA);
      @(negedge clk);
      chk("lat_turn_oe", 32'(bus_oe), 0);
      @(negedge clk);
      chk("lat_drive_oe", 32'(bus_oe), 1);
      wait_idle("t1_idle");

      // 12 words refilled as ready: bursts of 8 and 4
      burst_exp.push_back(8);
      burst_exp.push_back(4);
      for (int i = 0; i < 12; i++) push_word(4'(i ^ 5));
      wait_idle("t2_idle");

      // peer holds the bus while the FIFO fills
      @(posedge clk);
      #1;
      peer_val = 4'h6;
      peer_drv = 1'b1;
      burst_exp.push_back(4);
      push_word(4'h1);
      push_word(4'h2);
      push_word(4'h4);
      push_word(4'h8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_bus_oe", 32'(bus_oe), 0);
      end
      chk("full_tx_ready", 32'(u_if.tx_ready), 0);
      @(posedge clk);
      #1 peer_drv = 1'b0;
      wait_idle("t3_idle");
      chk("pre_contention_err", 32'(err), 0);

      // contention on 0x5 then retransmit
      burst_exp.push_back(1);
      burst_exp.push_back(1);
      push_word(4'h5);
      @(posedge clk);
      @(posedge clk);
      #1;
      cap_en   = 1'b0;
      peer_val = 4'h9;
      peer_drv = 1'b1;
      @(posedge clk);
      #1 cap_en = 1'b1;
      @(negedge clk);
      chk("cont_bus_oe", 32'(bus_oe), 0);
      chk("cont_err", 32'(err), 1);
      @(posedge clk);
      #1 peer_drv = 1'b0;
      wait_idle("t4_idle");
      chk("err_sticky", 32'(err), 1);

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 6; i++) push_word(4'(4'hF - i));
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_bus_oe", 32'(bus_oe), 0);
      chk("arst_tx_ready", 32'(u_if.tx_ready), 1);
      chk("arst_err", 32'(err), 0);
      tx_exp.delete();
      burst_exp.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("arst_rx_valid", 32'(u_if.rx_valid), 0);
      repeat (3) @(negedge clk);
      chk("arst_drained_oe", 32'(bus_oe), 0);

      // send 3, receive 2
      burst_exp.push_back(3);
      push_word(4'hC);
      push_word(4'hD);
      push_word(4'hE);
      wait_idle("t6_tx_idle");
      @(posedge clk);
      #1;
      peer_val = 4'h1;
      peer_drv = 1'b1;
      @(posedge clk);
      #1 peer_val = 4'h8;
      @(posedge clk);
      #1 peer_drv = 1'b0;
      wait_idle("t6_rx_idle");
`ifdef HDX_STATS_EN
      chk("stats_tx_count", 32'(tx_count), 3);
      chk("stats_rx_count", 32'(rx_count), 2);
`endif

      chk("tx_queue_left", 32'(tx_exp.size()), 0);
      chk("rx_queue_left", 32'(rx_exp.size()), 0);
      chk("burst_queue_left", 32'(burst_exp.size()), 0);
   endtask

   initial begin
      fork
         monitor();
         peer_cap();
         stimulus();
         begin
            #500000;
            fail_now("global_timeout");
         end
      join_any
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hdx_port.md
# hdx_port

Half-duplex port for a shared tristate data bus between two identical peers. Buffers outgoing words in a small FIFO, arbitrates for the bus using each side's output-enable, drives the bus in bursts with turnaround gaps, and captures words driven by the peer. Sits between the core's valid/ready stream logic and the physical tristate bus pins.

## Interface
- WIDTH, 4, bus and data word width.
- DEPTH, 4, TX FIFO depth (power of 2, ≥2).
- TURN, 1, idle cycles with peer_oe low required before driving (0..15).
- MAX_BURST, 8, maximum words per bus ownership (≥1).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_valid  input  1  tx_data is valid.
- tx_data  input  WIDTH  word to transmit.
- tx_ready  output  1  FIFO can accept (not full).
- rx_valid  output  1  one-cycle pulse: rx_data holds a new captured word.
- rx_data  output  WIDTH  last captured word.
- bus_data  inout  WIDTH  shared bus; driven only while bus_oe=1, else high-Z.
- bus_oe  output  1  this port is driving bus_data.
- peer_oe  input  1  peer is driving bus_data.
- err  output  1  sticky contention flag.

## Operation
- TX FIFO: push on rising edge when tx_valid && tx_ready; tx_ready = !full, combinational from occupancy. Push and pop in same cycle allowed when full (pop frees the slot only after the edge; tx_ready stays 0 that cycle).
- States: IDLE, TURN, DRIVE, RELEASE.
- IDLE: FIFO non-empty && peer_oe=0 → TURN, counter=TURN; if TURN=0 go straight to DRIVE.
- TURN: peer_oe=1 → IDLE (yield, no error). Else decrement; on reaching 0 → DRIVE.
- DRIVE: bus_oe=1 and output register=FIFO head, both registered on the edge entering/remaining in DRIVE; one pop per DRIVE cycle. Leave to RELEASE after the word that empties the FIFO or the MAX_BURST-th word. Pushes during DRIVE extend the burst.
- RELEASE: bus_oe=0 for exactly 1 cycle → IDLE.
- Contention: peer_oe=1 sampled while in DRIVE → bus_oe=0 next cycle, err←1, current word not popped (retransmitted later), → IDLE.
- RX: at each edge with bus_oe=0 && peer_oe=1, rx_data←bus_data, rx_valid←1; otherwise rx_valid←0, rx_data holds. No backpressure.
- err cleared only by reset.

## Timing
- Reset values: bus_oe=0, bus_data=Z, tx_ready=1, rx_valid=0, rx_data=0, err=0, state IDLE, FIFO empty, counters 0.
- Reset asserted mid-burst: bus_oe drops to 0 asynchronously; FIFO contents discarded.
- TX latency, idle bus, TURN=1: push at edge N → TURN after N+1 → first word on bus in cycle after edge N+2.
- RX latency: word on bus in cycle k → rx_valid/rx_data valid cycle k+1.
- Gap between two bursts of this port ≥ 1+TURN cycles with bus_oe=0.
- Both ports leaving TURN on the same edge drive together; both detect contention on the next edge and set err.

## Configuration
- HDX_STATS_EN defined: adds outputs tx_count and rx_count (16 bits each, reset 0, wrap at 0xFFFF→0), incremented per popped word (non-contended DRIVE cycle) and per rx_valid.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package hdx_pkg: state enum (IDLE, TURN, DRIVE, RELEASE), default WIDTH/DEPTH constants, stats counter width.
- Sub-module hdx_fifo: synchronous FIFO (push, pop, full, empty, head), pointer width log2(DEPTH)+1.

## Test plan
- Two ports back to back, TURN=1: push 0x3, 0xA into A → B rx_valid twice with 0x3 then 0xA on consecutive cycles; A bus_oe high exactly 2 cycles.
- Push 12 words into A (MAX_BURST=8, refill as ready) → bursts of 8 then 4, bus_oe low ≥2 cycles between, order preserved.
- Fill FIFO with 4 words, peer_oe held 1 → tx_ready=0, bus_oe never asserts; release peer_oe → all 4 sent.
- Force peer_oe=1 during A's DRIVE on word 0x5 → bus_oe 0 next cycle, err=1 sticky, 0x5 resent after peer_oe drops.
- Assert rst_n=0 mid-burst → bus_oe=0 immediately, tx_ready=1, err=0, rx_valid=0 after release.
- With HDX_STATS_EN: send 3, receive 2 → tx_count=3, rx_count=2.
